edf_arbiter: RTL and testbench
==============================

// Module: edf_arbiter
// PURPOSE
// - Earliest-deadline-first selector in the EDF interrupt controller, between the gateway cells and the core.
// - Sequentially scans the enabled, pending sources (pending flag ip, deadline dl) and picks the earliest deadline.
// - Presents the winner on a valid/ready handshake; on acceptance, pulses a one-hot claim back to that gateway.
// - Uses one comparator, time-shared over NrIrqs cycles, so area does not grow as an NrIrqs-wide tree.
// PARAMETERS
// - NrIrqs   4   number of interrupt sources, >= 2
// - TsWidth  64  deadline/timestamp width in bits
// - IdWidth  $clog2(NrIrqs)  localparam, source index width
// PORTS
// - clk_i        in   1                 clock
// - rst_ni       in   1                 reset, synchronous, active-low
// - ip_i         in   NrIrqs            per-source pending flag from gateways, sticky until claimed
// - ie_i         in   NrIrqs            per-source enable from config regs
// - dl_i         in   NrIrqs*TsWidth    per-source absolute deadline, packed [NrIrqs-1:0][TsWidth-1:0]
// - irq_id_o     out  IdWidth           selected source index
// - irq_valid_o  out  1                 selection valid
// - irq_ready_i  in   1                 core accepts selection
// - claim_o      out  NrIrqs            one-hot, 1-cycle pulse clearing the accepted gateway's pending flag
// - busy_o       out  1                 FSM not in IDLE
// BEHAVIOUR
// - Reset (rst_ni=0 at a clock edge):
//   - state=IDLE; irq_id_o=0, irq_valid_o=0, claim_o=0, busy_o=0.
//   - Internal scan index and best-candidate registers cleared.
//   - Reset mid-SCAN or mid-VALID aborts the operation; no claim is issued.
// - Eligible source i: ip_i[i] & ie_i[i], sampled in the cycle index i is examined.
// - earlier(a,b) = MSB of (a - b) computed mod 2^TsWidth, i.e. signed difference < 0.
//   - Wrap-safe provided live deadlines lie within 2^(TsWidth-1) of each other.
// - FSM states: IDLE, SCAN, VALID.
//   - IDLE:
//     - If |(ip_i & ie_i): go to SCAN with idx=0 and best_vld=0. Otherwise stay.
//   - SCAN (one source per cycle):
//     - If source idx is eligible and (!best_vld | earlier(dl_i[idx], best_dl)): best_id=idx, best_dl=dl_i[idx], best_vld=1.
//     - Ties are not earlier, so the lower index wins.
//     - idx increments each cycle.
//     - At idx==NrIrqs-1: go to VALID if best_vld (including this cycle's update); otherwise go to IDLE (all pends withdrawn or disabled).
//   - VALID:
//     - irq_valid_o=1; irq_id_o=best_id, held stable until handshake.
//     - On irq_valid_o & irq_ready_i: claim_o[best_id]=1 for exactly the next cycle, then IDLE.
//     - No preemption: new or earlier-deadline arrivals during SCAN at already-passed indices, or during VALID, wait for the next scan.
//     - Changes to ie_i or ip_i during VALID do not drop valid; the core resolves spurious claims.
// - Latency:
//   - Eligible ip_i in IDLE -> irq_valid_o high after NrIrqs+1 cycles (1 IDLE decision + NrIrqs SCAN).
//   - ready -> claim pulse after 1 cycle. Rescan can start no earlier than the cycle after the claim pulse.
// - The claim pulse and IDLE re-entry coincide. The IDLE check in that cycle may still see the claimed ip set, since the gateway clears it one cycle later.
//   - The next SCAN then re-samples and ignores it.
// - irq_ready_i while !irq_valid_o is ignored.
// - busy_o = (state != IDLE).
// STRUCTURE
// - Package edf_ic_pkg:
//   - typedef enum logic [1:0] {IDLE, SCAN, VALID} edf_arb_state_e
//   - function automatic logic dl_earlier(a,b), parameterised by TsWidth via a package localparam TsWidth=64
//   - typedef logic [TsWidth-1:0] ts_t
// - Sub-module edf_dl_cmp: combinational earlier() comparator. Single instance here; reused later by a preemption checker.
// - Top level holds the FSM, idx counter, best_id/best_dl/best_vld registers and the claim register.
// TESTING
// - Single source: ip=0001, ie=1111, dl0=100 -> valid after 5 cycles, id=0; ready -> claim=0001 for 1 cycle, then IDLE.
// - EDF pick: ip=1111, dl={3:40, 2:10, 1:30, 0:20} -> id=2; claim it, drop ip2, rescan -> id=0.
// - Tie and enable: dl all 50, ip=1111 -> id=0; ie=1110 -> id=1; ie=0000 -> stays IDLE, valid never set.
// - Wrap-around, TsWidth=64: dl0=64'hFFFF_FFFF_FFFF_FFF0, dl1=64'h10, ip=0011 -> id=0 (dl0 earlier across the wrap).
// - Backpressure and no preemption: hold ready=0 for 20 cycles with id=1 valid; raise ip3 with dl=1 -> id stays 1 and stable; after claim, next pick is id=3.
// - Reset mid-SCAN and mid-VALID: rst_ni=0 one cycle -> all outputs 0 the next cycle, no claim pulse; the scan restarts from idx 0.

Source files
------------

// File: rtl/edf_ic_pkg.sv
// Shared types and helpers for the EDF interrupt controller.
// Contents: arbiter FSM state enum, timestamp type, wrap-safe deadline compare.
// Used by the arbiter and, later, by the preemption checker.
package edf_ic_pkg;

  localparam int TsWidth = 64;

  typedef logic [TsWidth-1:0] ts_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    VALID
  } edf_arb_state_e;

  // a is earlier than b when the modular difference is negative. This stays
  // correct across timestamp wrap as long as live deadlines are within half
  // the timestamp range of each other.
  function automatic logic dl_earlier(input ts_t a, input ts_t b);
    ts_t diff;
    diff = a - b;
    return diff[TsWidth-1];
  endfunction

endpackage

// File: rtl/edf_dl_cmp.sv
// Wrap-safe deadline comparator: earlier_o = (a_i - b_i) mod 2^TsWidth is negative.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
// Ports: a_i, b_i (TsWidth deadlines), earlier_o (a_i strictly earlier than b_i).
module edf_dl_cmp #(
  parameter int TsWidth = 64
) (
  input  logic [TsWidth-1:0] a_i,
  input  logic [TsWidth-1:0] b_i,
  output logic               earlier_o
);

  logic [TsWidth-1:0] diff;

  assign diff      = a_i - b_i;
  assign earlier_o = diff[TsWidth-1];

endmodule

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first selector: scans one source per cycle with a single comparator.
// Latency: pending+enabled source to irq_valid_o in NrIrqs+1 cycles; ready to claim pulse in 1 cycle.
// Backpressure: irq_valid_o/irq_id_o held stable until irq_ready_i; no preemption while waiting.
// Ports: clk_i, rst_ni (sync, active-low), ip_i/ie_i/dl_i per-source inputs,
//        irq_id_o/irq_valid_o/irq_ready_i core handshake, claim_o one-hot pulse, busy_o.
module edf_arbiter #(
  parameter  int NrIrqs  = 4,
  parameter  int TsWidth = 64,
  localparam int IdWidth = $clog2(NrIrqs)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrIrqs-1:0]               ip_i,
  input  logic [NrIrqs-1:0]               ie_i,
  input  logic [NrIrqs-1:0][TsWidth-1:0]  dl_i,
  output logic [IdWidth-1:0]              irq_id_o,
  output logic                            irq_valid_o,
  input  logic                            irq_ready_i,
  output logic [NrIrqs-1:0]               claim_o,
  output logic                            busy_o
);

  import edf_ic_pkg::*;

  edf_arb_state_e       state_q, state_d;
  logic [IdWidth-1:0]   idx_q, idx_d;
  logic [IdWidth-1:0]   best_id_q, best_id_d;
  logic [TsWidth-1:0]   best_dl_q, best_dl_d;
  logic                 best_vld_q, best_vld_d;
  logic [NrIrqs-1:0]    claim_q, claim_d;

  logic [TsWidth-1:0]   cand_dl;
  logic                 cand_elig;
  logic                 cand_earlier;
  logic                 take;

  // The one comparator is time-shared: candidate at idx vs. running best.
  assign cand_dl   = dl_i[idx_q];
  assign cand_elig = ip_i[idx_q] & ie_i[idx_q];

  edf_dl_cmp #(
    .TsWidth (TsWidth)
  ) u_cmp (
    .a_i       (cand_dl),
    .b_i       (best_dl_q),
    .earlier_o (cand_earlier)
  );

  // Strictly-earlier only, so on ties the lower index already held wins.
  assign take = cand_elig & (~best_vld_q | cand_earlier);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_id_d  = best_id_q;
    best_dl_d  = best_dl_q;
    best_vld_d = best_vld_q;
    claim_d    = '0;

    case (state_q)
      IDLE: begin
        if (|(ip_i & ie_i)) begin
          state_d    = SCAN;
          idx_d      = '0;
          best_vld_d = 1'b0;
        end
      end

      SCAN: begin
        if (take) begin
          best_id_d  = idx_q;
          best_dl_d  = cand_dl;
          best_vld_d = 1'b1;
        end
        if (idx_q == IdWidth'(NrIrqs - 1)) begin
          // Everything may have been withdrawn or disabled mid-scan.
          state_d = (best_vld_q | take) ? VALID : IDLE;
        end else begin
          idx_d = idx_q + IdWidth'(1);
        end
      end

      VALID: begin
        if (irq_ready_i) begin
          claim_d = NrIrqs'(1) << best_id_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      best_id_q  <= '0;
      best_dl_q  <= '0;
      best_vld_q <= 1'b0;
      claim_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_id_q  <= best_id_d;
      best_dl_q  <= best_dl_d;
      best_vld_q <= best_vld_d;
      claim_q    <= claim_d;
    end
  end

  assign irq_valid_o = (state_q == VALID);
  assign irq_id_o    = best_id_q;
  assign claim_o     = claim_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_edf_arbiter.sv
// Self-checking bench for edf_arbiter: directed scenarios plus randomized
// deadline sets checked against a reference pick computed from signed offsets.
module tb_edf_arbiter;

  logic             clk_i;
  logic             rst_ni;
  logic [3:0]       ip;
  logic [3:0]       ie;
  logic [3:0][63:0] dl;
  logic [1:0]       irq_id_o;
  logic             irq_valid_o;
  logic             irq_ready_i;
  logic [3:0]       claim_o;
  logic             busy_o;

  int errors = 0;
  int checks = 0;

  edf_arbiter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ip_i        (ip),
    .ie_i        (ie),
    .dl_i        (dl),
    .irq_id_o    (irq_id_o),
    .irq_valid_o (irq_valid_o),
    .irq_ready_i (irq_ready_i),
    .claim_o     (claim_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference pick: express every eligible deadline as a signed offset from the
  // first eligible one, take the smallest offset, lowest index on ties.
  function automatic int model_pick(input logic [3:0] p, input logic [3:0] e,
                                    input logic [3:0][63:0] d);
    int          best = -1;
    logic [63:0] ref_dl = '0;
    longint      best_off = 0;
    for (int i = 0; i < 4; i++) begin
      if (p[i] && e[i]) begin
        longint off;
        if (best < 0) ref_dl = d[i];
        off = longint'(d[i] - ref_dl);
        if (best < 0 || off < best_off) begin
          best     = i;
          best_off = off;
        end
      end
    end
    return best;
  endfunction

  // Wait for irq_valid_o, then check latency and selected id.
  task automatic wait_valid(input string tag, input int exp_lat, input int exp_id);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 30) begin
      step();
      n++;
      if (n == 1) chk({tag, "_claim_1cyc"}, 64'(claim_o), 64'd0);
      if (irq_valid_o) seen = 1'b1;
    end
    chk({tag, "_valid_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
      chk({tag, "_id"}, 64'(irq_id_o), 64'(exp_id));
    end
  endtask

  // Handshake one cycle; gateway behaviour clears the claimed pending bit.
  task automatic accept(input string tag, input int exp_id);
    logic [3:0] oh;
    oh = 4'b0001 << exp_id;
    irq_ready_i = 1'b1;
    step();
    irq_ready_i = 1'b0;
    chk({tag, "_claim"}, 64'(claim_o), 64'(oh));
    chk({tag, "_valid_drop"}, 64'(irq_valid_o), 64'd0);
    chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    ip = ip & ~claim_o;
  endtask

  task automatic drain();
    ip = 4'b0000;
    repeat (6) step();
  endtask

  initial begin
    logic [63:0] base;
    longint      off;
    int          exp;
    bit          stable;
    bit          any_act;

    rst_ni      = 1'b0;
    irq_ready_i = 1'b0;
    ip          = 4'b0000;
    ie          = 4'b1111;
    dl          = '0;
    step();
    step();
    chk("rst_valid", 64'(irq_valid_o), 64'd0);
    chk("rst_id",    64'(irq_id_o),    64'd0);
    chk("rst_claim", 64'(claim_o),     64'd0);
    chk("rst_busy",  64'(busy_o),      64'd0);
    rst_ni = 1'b1;
    step();

    // Single source
    dl[0] = 64'd100;
    ip    = 4'b0001;
    wait_valid("single", 5, 0);
    accept("single", 0);
    drain();

    // EDF pick then rescan after the winner is withdrawn
    dl = {64'd40, 64'd10, 64'd30, 64'd20};
    ip = 4'b1111;
    wait_valid("edf1", 5, 2);
    accept("edf1", 2);
    wait_valid("edf2", 5, 0);
    accept("edf2", 0);
    drain();

    // Ties and enables
    dl = {64'd50, 64'd50, 64'd50, 64'd50};
    ip = 4'b1111;
    wait_valid("tie", 5, 0);
    accept("tie", 0);
    ip = 4'b1111;
    ie = 4'b1110;
    wait_valid("ie_mask", 5, 1);
    accept("ie_mask", 1);
    ie = 4'b0000;
    ip = 4'b1111;
    any_act = 1'b0;
    repeat (10) begin
      step();
      if (irq_valid_o || busy_o) any_act = 1'b1;
    end
    chk("ie_none_idle", 64'(any_act), 64'd0);
    ie = 4'b1111;
    drain();

    // Wrap-around
    dl[0] = 64'hFFFF_FFFF_FFFF_FFF0;
    dl[1] = 64'h10;
    ip    = 4'b0011;
    wait_valid("wrap", 5, 0);
    accept("wrap", 0);
    drain();

    // Backpressure, no preemption
    dl = {64'd1000, 64'd700, 64'd500, 64'd900};
    ip = 4'b0010;
    wait_valid("bp", 5, 1);
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        dl[3] = 64'd1;
        ip[3] = 1'b1;
      end
      step();
      if (!irq_valid_o || irq_id_o !== 2'd1) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    accept("bp", 1);
    wait_valid("bp_next", 5, 3);
    accept("bp_next", 3);
    drain();

    // Reset mid-SCAN, after a best candidate has been recorded
    ip = 4'b0100;
    repeat (4) step();
    chk("rscan_busy_pre", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    step();
    chk("rscan_valid", 64'(irq_valid_o), 64'd0);
    chk("rscan_busy",  64'(busy_o),      64'd0);
    chk("rscan_id",    64'(irq_id_o),    64'd0);
    chk("rscan_claim", 64'(claim_o),     64'd0);
    rst_ni = 1'b1;
    wait_valid("rscan_retry", 5, 2);

    // Reset mid-VALID with ready asserted: no claim may escape
    irq_ready_i = 1'b1;
    rst_ni      = 1'b0;
    step();
    irq_ready_i = 1'b0;
    rst_ni      = 1'b1;
    chk("rvalid_claim", 64'(claim_o),     64'd0);
    chk("rvalid_valid", 64'(irq_valid_o), 64'd0);
    chk("rvalid_id",    64'(irq_id_o),    64'd0);
    chk("rvalid_busy",  64'(busy_o),      64'd0);
    wait_valid("rvalid_retry", 5, 2);
    accept("rvalid_retry", 2);
    drain();

    // Randomized deadline sets
    for (int it = 0; it < 24; it++) begin
      base = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        if (it % 2 == 1) off = longint'($urandom_range(0, 2000)) - 1000;
        else             off = $signed({$urandom, $urandom}) >>> 3;
        dl[i] = base + 64'(off);
      end
      if (it % 3 == 0) dl[$urandom_range(0, 3)] = dl[$urandom_range(0, 3)];
      ie = 4'($urandom_range(1, 15));
      ip = 4'($urandom_range(0, 15));
      while ((ip & ie) == 4'b0000) ip = 4'($urandom_range(0, 15));
      exp = model_pick(ip, ie, dl);
      wait_valid($sformatf("rnd%0d", it), 5, exp);
      accept($sformatf("rnd%0d", it), exp);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
